phasegen: RTL and testbench

Phase generator for the KAPPA3 multicycle core. Drives the one-hot `cstate` bus consumed by the controller (IF=4'b0001, DE=4'b0010, EX=4'b0100, WB=4'b1000; 4'b0000 = idle), and adds the run control used on the board: run, stop, phase-step, instruction-step, PC breakpoint and memory wait states. It also keeps a retired-instruction counter.

---
 rtl/phasegen.sv | 112 +++++++++++
 tb/tb_phasegen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/phasegen.sv
// KAPPA3 phase generator: one-hot IF/DE/EX/WB sequencing with run/stop/step control and PC breakpoint.
// Commands take effect the cycle after they are sampled; WB is held while the memory access is not ready.
module phasegen (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        stop,
    input  logic        step_phase,
    input  logic        step_inst,
    input  logic        bp_en,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic [3:0]  cstate,
    output logic        running,
    output logic        bp_hit,
    output logic [31:0] inst_count
);

    typedef enum logic [1:0] {
        M_STOP   = 2'd0,
        M_RUN    = 2'd1,
        M_SPHASE = 2'd2,
        M_SINST  = 2'd3
    } mode_e;

    localparam logic [3:0] PH_IF = 4'b0001;
    localparam logic [3:0] PH_WB = 4'b1000;

    mode_e       mode_q, mode_d;
    logic [3:0]  nphase_q, nphase_d;
    logic        skip_bp_q, skip_bp_d;
    logic        bp_hit_q, bp_hit_d;
    logic        stop_pend_q, stop_pend_d;
    logic [31:0] inst_count_q, inst_count_d;

    logic active;
    logic bp_trip;
    logic wb_wait;
    logic advance;
    logic wb_done;
    logic stop_req;
    logic leave;

    always_comb begin
        active   = (mode_q != M_STOP);
        // Single-phase stepping deliberately ignores the breakpoint.
        bp_trip  = active && (mode_q != M_SPHASE) && (nphase_q == PH_IF) &&
                   bp_en && (pc == bp_addr) && !skip_bp_q;
        wb_wait  = (nphase_q == PH_WB) && mem_req && !mem_ready;
        advance  = active && !bp_trip && !wb_wait;
        wb_done  = advance && (nphase_q == PH_WB);
        stop_req = stop_pend_q || stop;
        leave    = ((mode_q == M_SPHASE) && advance) ||
                   (wb_done && ((mode_q == M_SINST) || stop_req));

        mode_d       = mode_q;
        nphase_d     = nphase_q;
        skip_bp_d    = skip_bp_q;
        bp_hit_d     = bp_hit_q;
        stop_pend_d  = stop_pend_q;
        inst_count_d = inst_count_q;

        if (!active) begin
            if (step_inst || step_phase || run) begin
                skip_bp_d = 1'b1;
                bp_hit_d  = 1'b0;
                if (step_inst)       mode_d = M_SINST;
                else if (step_phase) mode_d = M_SPHASE;
                else                 mode_d = M_RUN;
            end
        end else if (bp_trip) begin
            mode_d      = M_STOP;
            bp_hit_d    = 1'b1;
            stop_pend_d = 1'b0;
        end else begin
            stop_pend_d = stop_req;
            if (nphase_q == PH_IF) skip_bp_d = 1'b0;
            if (advance)           nphase_d = {nphase_q[2:0], nphase_q[3]};
            if (wb_done)           inst_count_d = inst_count_q + 32'd1;
            if (leave) begin
                mode_d      = M_STOP;
                stop_pend_d = 1'b0;
            end
        end

        cstate     = (active && !bp_trip) ? nphase_q : 4'b0000;
        running    = active;
        bp_hit     = bp_hit_q;
        inst_count = inst_count_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q       <= M_STOP;
            nphase_q     <= PH_IF;
            skip_bp_q    <= 1'b0;
            bp_hit_q     <= 1'b0;
            stop_pend_q  <= 1'b0;
            inst_count_q <= 32'd0;
        end else begin
            mode_q       <= mode_d;
            nphase_q     <= nphase_d;
            skip_bp_q    <= skip_bp_d;
            bp_hit_q     <= bp_hit_d;
            stop_pend_q  <= stop_pend_d;
            inst_count_q <= inst_count_d;
        end
    end

endmodule

// File: tb/tb_phasegen.sv
// Bench for phasegen: directed test-plan scenarios plus random run control against a phase-index model.
module tb_phasegen;

    logic        clock = 1'b0;
    logic        reset;
    logic        run, stop, step_phase, step_inst, bp_en, mem_req, mem_ready;
    logic [31:0] bp_addr, pc;
    logic [3:0]  cstate;
    logic        running, bp_hit;
    logic [31:0] inst_count;

    int checks = 0;
    int errors = 0;

    localparam int MS = 0, MR = 1, MP = 2, MI = 3;
    int          m_mode, m_ph;
    bit          m_skip, m_hit, m_pend;
    logic [31:0] m_cnt;
    logic [3:0]  seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    always #5 clock = ~clock;

    phasegen dut (
        .clock(clock), .reset(reset), .run(run), .stop(stop),
        .step_phase(step_phase), .step_inst(step_inst), .bp_en(bp_en),
        .bp_addr(bp_addr), .pc(pc), .mem_req(mem_req), .mem_ready(mem_ready),
        .cstate(cstate), .running(running), .bp_hit(bp_hit), .inst_count(inst_count)
    );

    function automatic logic m_bp();
        return (m_mode == MR || m_mode == MI) && m_ph == 0 && bp_en &&
               pc == bp_addr && !m_skip;
    endfunction

    function automatic logic [3:0] m_cstate();
        logic [3:0] one = 4'b0001;
        if (m_mode == MS || m_bp()) return 4'b0000;
        return one << m_ph;
    endfunction

    task automatic model_reset();
        m_mode = MS; m_ph = 0; m_skip = 0; m_hit = 0; m_pend = 0; m_cnt = 0;
    endtask

    task automatic cyc(input logic r, s, sp, si, be, mq, mr, input logic [31:0] p);
        @(negedge clock);
        run = r; stop = s; step_phase = sp; step_inst = si;
        bp_en = be; mem_req = mq; mem_ready = mr; pc = p;
        #1;
    endtask

    // Model advance at the clock edge, in terms of phase index and instruction retirement.
    task automatic adv();
        bit stall, retire, leave;
        @(posedge clock);
        if (m_mode == MS) begin
            if (step_inst || step_phase || run) begin
                m_skip = 1; m_hit = 0;
                m_mode = step_inst ? MI : (step_phase ? MP : MR);
            end
        end else if (m_bp()) begin
            m_mode = MS; m_hit = 1; m_pend = 0;
        end else begin
            stall  = (m_ph == 3) && mem_req && !mem_ready;
            retire = (m_ph == 3) && !stall;
            if (stop) m_pend = 1;
            if (m_ph == 0) m_skip = 0;
            if (!stall) m_ph = (m_ph + 1) % 4;
            if (retire) m_cnt = m_cnt + 1;
            leave = (m_mode == MP && !stall) || (m_mode == MI && retire) ||
                    (m_mode == MR && retire && m_pend);
            if (leave) begin m_mode = MS; m_pend = 0; end
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        run = 0; stop = 0; step_phase = 0; step_inst = 0; bp_en = 0; mem_req = 0; mem_ready = 1; pc = 0;
        #1;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (cstate !== 4'b0000) begin errors++; $display("FAIL reset_cstate got %b want 0000", cstate); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
        checks++; if (bp_hit !== 1'b0) begin errors++; $display("FAIL reset_bp_hit got %b want 0", bp_hit); end
        checks++; if (inst_count !== 32'd0) begin errors++; $display("FAIL reset_inst_count got %0d want 0", inst_count); end
        @(negedge clock);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_run();
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (cstate !== 4'b0000) begin errors++; $display("FAIL run_cmd_cycle got %b want 0000", cstate); end
        adv();
        for (int i = 0; i < 16; i++) begin
            cyc(0, i == 14, 0, 0, 0, 0, 1, 0);
            checks++; if (cstate !== seq[i % 4]) begin errors++; $display("FAIL run_phase[%0d] got %b want %b", i, cstate, seq[i % 4]); end
            if (i == 12) begin
                checks++; if (inst_count !== 32'd3) begin errors++; $display("FAIL run_count12 got %0d want 3", inst_count); end
            end
            adv();
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (cstate !== 4'b0000 || running !== 1'b0) begin errors++; $display("FAIL run_stop_at_wb got %b/%b want 0000/0", cstate, running); end
        checks++; if (inst_count !== 32'd4) begin errors++; $display("FAIL run_stop_count got %0d want 4", inst_count); end
        adv();
    endtask

    task automatic test_step_phase();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 1, 0, 0, 0, 1, 0);
            checks++; if (cstate !== 4'b0000) begin errors++; $display("FAIL sphase_gap[%0d] got %b want 0000", k, cstate); end
            adv();
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            checks++; if (cstate !== seq[k]) begin errors++; $display("FAIL sphase_phase[%0d] got %b want %b", k, cstate, seq[k]); end
            adv();
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (cstate !== 4'b0000 || running !== 1'b0) begin errors++; $display("FAIL sphase_end got %b/%b want 0000/0", cstate, running); end
        checks++; if (inst_count !== 32'd1) begin errors++; $display("FAIL sphase_count got %0d want 1", inst_count); end
        adv();
    endtask

    task automatic test_step_inst();
        logic [3:0] exp_cs [9] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
        logic       rdy    [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 0, i == 0, 0, 1, rdy[i], 0);
            checks++; if (cstate !== exp_cs[i]) begin errors++; $display("FAIL sinst_phase[%0d] got %b want %b", i, cstate, exp_cs[i]); end
            adv();
        end
        checks++; if (inst_count !== 32'd1 || running !== 1'b0) begin errors++; $display("FAIL sinst_end got %0d/%b want 1/0", inst_count, running); end
    endtask

    task automatic test_breakpoint();
        do_reset();
        cyc(1, 0, 0, 0, 1, 0, 1, 32'hF8);
        adv();
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 0, 1, 0, 1, 32'hF8 + 32'(4 * (i / 4)));
            checks++; if (cstate !== seq[i % 4]) begin errors++; $display("FAIL bp_pre[%0d] got %b want %b", i, cstate, seq[i % 4]); end
            adv();
        end
        cyc(0, 0, 0, 0, 1, 0, 1, 32'h100);
        checks++; if (cstate !== 4'b0000 || running !== 1'b1 || bp_hit !== 1'b0) begin
            errors++; $display("FAIL bp_trip_cycle got %b/%b/%b want 0000/1/0", cstate, running, bp_hit); end
        adv();
        cyc(0, 0, 0, 0, 1, 0, 1, 32'h100);
        checks++; if (running !== 1'b0 || bp_hit !== 1'b1 || inst_count !== 32'd2) begin
            errors++; $display("FAIL bp_halted got %b/%b/%0d want 0/1/2", running, bp_hit, inst_count); end
        adv();
        cyc(1, 0, 0, 0, 1, 0, 1, 32'h100);
        checks++; if (bp_hit !== 1'b1) begin errors++; $display("FAIL bp_sticky got %b want 1", bp_hit); end
        adv();
        cyc(0, 0, 0, 0, 1, 0, 1, 32'h100);
        checks++; if (cstate !== 4'b0001 || bp_hit !== 1'b0 || running !== 1'b1) begin
            errors++; $display("FAIL bp_resume got %b/%b/%b want 0001/0/1", cstate, bp_hit, running); end
        adv();
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(1, 0, 0, 0, 0, 0, 1, 0);
        adv();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            adv();
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (cstate !== 4'b0010 || inst_count !== 32'd1) begin errors++; $display("FAIL areset_pre got %b/%0d want 0010/1", cstate, inst_count); end
        #2 reset = 1'b0;
        #1;
        checks++; if (cstate !== 4'b0000 || running !== 1'b0) begin errors++; $display("FAIL areset_cstate got %b/%b want 0000/0", cstate, running); end
        checks++; if (inst_count !== 32'd0) begin errors++; $display("FAIL areset_count got %0d want 0", inst_count); end
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            cyc($urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                $urandom_range(0, 4) != 0, 32'hFC + 32'(4 * $urandom_range(0, 2)));
            checks++; if (cstate !== m_cstate()) begin errors++; $display("FAIL rand_cstate[%0d] got %b want %b", n, cstate, m_cstate()); end
            checks++; if (running !== (m_mode != MS)) begin errors++; $display("FAIL rand_running[%0d] got %b want %b", n, running, m_mode != MS); end
            checks++; if (bp_hit !== m_hit) begin errors++; $display("FAIL rand_bp_hit[%0d] got %b want %b", n, bp_hit, m_hit); end
            checks++; if (inst_count !== m_cnt) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", n, inst_count, m_cnt); end
            adv();
        end
    endtask

    initial begin
        reset = 1'b0;
        run = 0; stop = 0; step_phase = 0; step_inst = 0; bp_en = 0;
        mem_req = 0; mem_ready = 1; pc = 0; bp_addr = 32'h100;
        model_reset();
        test_reset();
        test_run();
        test_step_phase();
        test_step_inst();
        test_breakpoint();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
